// File: rtl/split_frame_loader_if.sv
// Word-stream input and verdict output handshakes of split_frame_loader.
// The master side is the frame source plus verdict consumer; the slave side is the loader.
interface split_frame_loader_if #(
  parameter int unsigned WORD_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic              res_valid;
  logic              res_ready;
  logic              res_sat;
  logic              res_err;

  modport master (
    output in_valid, in_data, in_last, res_ready,
    input  in_ready, res_valid, res_sat, res_err
  );

  modport slave (
    input  in_valid, in_data, in_last, res_ready,
    output in_ready, res_valid, res_sat, res_err
  );
endinterface

// File: rtl/split_frame_loader.sv
// Packs a word stream into the flat var_* vector of a split constraint module,
// samples its x output once the vector is complete, and returns a sat/error verdict.
module split_frame_loader #(
  parameter int unsigned TOTAL_BITS = 1024,
  parameter int unsigned WORD_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  split_frame_loader_if.slave   bus,
  output logic [TOTAL_BITS-1:0] vec_out,
  input  logic                  chk_x,
  output logic [15:0]           sat_count
);
  localparam int unsigned NWORDS = (TOTAL_BITS + WORD_W - 1) / WORD_W;
  localparam int unsigned CNT_W  = $clog2(NWORDS) + 1;
  localparam int unsigned SAT_W  = 16;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    EVAL  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      wcnt;
  logic [TOTAL_BITS-1:0] vec_nxt;
  logic                  in_fire;
  logic                  res_fire;
  logic                  at_last_word;
  logic                  load_en;
  logic                  eval_en;
  logic                  err_en;
  logic                  res_valid_q;
  logic                  res_sat_q;
  logic                  res_err_q;

  assign in_fire      = bus.in_valid && ((state == LOAD) || (state == DRAIN));
  assign res_fire     = (state == RESP) && bus.res_ready;
  assign at_last_word = (wcnt == LAST_IDX);

  assign bus.res_valid = res_valid_q;
  assign bus.res_sat   = res_sat_q;
  assign bus.res_err   = res_err_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD: begin
        if (in_fire && bus.in_last)       state_nxt = at_last_word ? EVAL : RESP;
        else if (in_fire && at_last_word) state_nxt = DRAIN;
      end
      DRAIN:   if (in_fire && bus.in_last) state_nxt = RESP;
      EVAL:    state_nxt = RESP;
      RESP:    if (bus.res_ready) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Output / control decode; a frame is in error when in_last disagrees with the word position
  always_comb begin
    bus.in_ready = 1'b0;
    load_en      = 1'b0;
    eval_en      = 1'b0;
    err_en       = 1'b0;
    unique case (state)
      LOAD: begin
        bus.in_ready = 1'b1;
        load_en      = in_fire;
        err_en       = in_fire && (bus.in_last != at_last_word);
      end
      DRAIN:   bus.in_ready = 1'b1;
      EVAL:    eval_en      = 1'b1;
      RESP:    bus.in_ready = 1'b0;
      default: bus.in_ready = 1'b0;
    endcase
  end

  // Word wcnt lands at bit offset wcnt*WORD_W; bits past TOTAL_BITS have no home and drop
  always_comb begin
    vec_nxt = vec_out;
    for (int unsigned b = 0; b < TOTAL_BITS; b++) begin
      if (CNT_W'(b / WORD_W) == wcnt) vec_nxt[b] = bus.in_data[b % WORD_W];
    end
  end

  // Datapath and verdict registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_out     <= '0;
      wcnt        <= '0;
      res_valid_q <= 1'b0;
      res_sat_q   <= 1'b0;
      res_err_q   <= 1'b0;
      sat_count   <= '0;
    end else begin
      res_valid_q <= (state_nxt == RESP);
      if (load_en) begin
        vec_out <= vec_nxt;
        wcnt    <= wcnt + CNT_W'(1);
      end
      if (err_en) begin
        res_sat_q <= 1'b0;
        res_err_q <= 1'b1;
      end
      if (eval_en) begin
        res_sat_q <= chk_x;
        res_err_q <= 1'b0;
      end
      if (res_fire) begin
        wcnt <= '0;
        if (res_sat_q && (sat_count != '1)) sat_count <= sat_count + SAT_W'(1);
      end
    end
  end
endmodule
